// File: rtl/blur_kernel_sequencer.sv
// Walks every pixel of one octave, fetches its edge-clamped 3x3 neighbourhood,
// hands the kernel to the blur unit and writes the result back to memory.
module blur_kernel_sequencer #(
    parameter int WIDTH      = 128,
    parameter int HEIGHT     = 128,
    parameter int BIT_DEPTH  = 8,
    parameter int RD_LATENCY = 2,
    parameter int TIMEOUT    = 64,
    localparam int ADDR_W    = $clog2(WIDTH * HEIGHT * 2)
) (
    input  logic                   clk_in,
    input  logic                   rst_in_n,
    input  logic                   start_in,
    input  logic [1:0]             level_in,
    input  logic [ADDR_W-1:0]      src_base_in,
    input  logic [ADDR_W-1:0]      dst_base_in,
    output logic [ADDR_W-1:0]      rd_addr_out,
    output logic                   rd_en_out,
    input  logic [BIT_DEPTH-1:0]   rd_data_in,
    output logic [3*BIT_DEPTH-1:0] row0_out,
    output logic [3*BIT_DEPTH-1:0] row1_out,
    output logic [3*BIT_DEPTH-1:0] row2_out,
    output logic                   blur_valid_out,
    input  logic [BIT_DEPTH-1:0]   blur_data_in,
    input  logic                   blur_valid_in,
    output logic [ADDR_W-1:0]      wr_addr_out,
    output logic [BIT_DEPTH-1:0]   wr_data_out,
    output logic                   wr_en_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   error_out,
    output logic [2:0]             fsm_state_out
);

    localparam int LOG2_W     = $clog2(WIDTH);
    localparam int FETCH_LAST = 9 + RD_LATENCY;
    localparam int CNT_W      = $clog2(FETCH_LAST + 1);
    localparam int WT_W       = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ONE = 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_BLUR = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_NEXT      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           kx, ky, lvl;
    logic [ADDR_W-1:0]    x, y, src_base, dst_base;
    logic [WT_W-1:0]      wait_cnt;
    logic [BIT_DEPTH-1:0] result;
    logic                 error_q;
    logic [BIT_DEPTH-1:0] slot [0:8];

    logic [ADDR_W-1:0] w_m1, h_m1, cx, cy;
    logic [5:0]        w_shift;
    logic              issue, capture;
    logic [3:0]        cap_idx;

    assign w_m1    = ADDR_W'((WIDTH >> lvl) - 1);
    assign h_m1    = ADDR_W'((HEIGHT >> lvl) - 1);
    assign w_shift = 6'(LOG2_W) - {4'd0, lvl};

    // Neighbour coordinates saturate at the image border instead of wrapping.
    always_comb begin
        cx = x;
        cy = y;
        if (kx == 2'd0)      cx = (x == '0) ? x : x - ONE;
        else if (kx == 2'd2) cx = (x == w_m1) ? x : x + ONE;
        if (ky == 2'd0)      cy = (y == '0) ? y : y - ONE;
        else if (ky == 2'd2) cy = (y == h_m1) ? y : y + ONE;
    end

    // Read k issues at fetch count k and its data is taken RD_LATENCY counts later.
    assign issue   = (state == S_FETCH) && (cnt < CNT_W'(9));
    assign capture = (state == S_FETCH) && (cnt >= CNT_W'(RD_LATENCY))
                     && (cnt < CNT_W'(FETCH_LAST));
    assign cap_idx = 4'(cnt - CNT_W'(RD_LATENCY));

    assign rd_en_out   = issue;
    assign rd_addr_out = issue ? src_base + (cy << w_shift) + cx : '0;

    // Blur handshake: blur_valid_out is a one-cycle strobe with rows stable;
    // the unit answers later with a one-cycle blur_valid_in, no backpressure.
    assign blur_valid_out = (state == S_FETCH) && (cnt == CNT_W'(FETCH_LAST));
    assign row0_out = {slot[2], slot[1], slot[0]};
    assign row1_out = {slot[5], slot[4], slot[3]};
    assign row2_out = {slot[8], slot[7], slot[6]};

    assign wr_en_out   = (state == S_WRITE);
    assign wr_addr_out = wr_en_out ? dst_base + (y << w_shift) + x : '0;
    assign wr_data_out = wr_en_out ? result : '0;

    assign busy_out      = (state != S_IDLE);
    assign done_out      = (state == S_DONE);
    assign error_out     = error_q;
    assign fsm_state_out = state;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            kx       <= '0;
            ky       <= '0;
            lvl      <= '0;
            x        <= '0;
            y        <= '0;
            src_base <= '0;
            dst_base <= '0;
            wait_cnt <= '0;
            result   <= '0;
            error_q  <= 1'b0;
            for (int i = 0; i < 9; i++) slot[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        lvl      <= level_in;
                        src_base <= src_base_in;
                        dst_base <= dst_base_in;
                        x        <= '0;
                        y        <= '0;
                        cnt      <= '0;
                        kx       <= '0;
                        ky       <= '0;
                        error_q  <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        if (kx == 2'd2) begin
                            kx <= 2'd0;
                            ky <= ky + 2'd1;
                        end else begin
                            kx <= kx + 2'd1;
                        end
                    end
                    if (capture) slot[cap_idx] <= rd_data_in;
                    if (cnt == CNT_W'(FETCH_LAST)) begin
                        cnt      <= '0;
                        kx       <= '0;
                        ky       <= '0;
                        wait_cnt <= '0;
                        state    <= S_WAIT_BLUR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_BLUR: begin
                    if (blur_valid_in) begin
                        result <= blur_data_in;
                        state  <= S_WRITE;
                    end else if (wait_cnt == WT_W'(TIMEOUT - 1)) begin
                        error_q <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WT_W'(1);
                    end
                end
                S_WRITE: state <= S_NEXT;
                S_NEXT: begin
                    if (x != w_m1) begin
                        x     <= x + ONE;
                        state <= S_FETCH;
                    end else begin
                        x <= '0;
                        if (y == h_m1) begin
                            y     <= '0;
                            state <= S_DONE;
                        end else begin
                            y     <= y + ONE;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/blur_kernel_sequencer.md
BLUR_KERNEL_SEQUENCER -- requirements
Module: blur_kernel_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 128, octave-0 image width in pixels (power of two).
REQ-002 SHALL have parameter HEIGHT, default 128, octave-0 image height in pixels (power of two).
REQ-003 SHALL have parameter BIT_DEPTH, default 8, pixel width.
REQ-004 SHALL have parameter RD_LATENCY, default 2, cycles from rd_en_out to valid rd_data_in.
REQ-005 SHALL have parameter TIMEOUT, default 64, maximum cycles spent waiting for the blur result.
REQ-006 SHALL have local ADDR_W = $clog2(WIDTH*HEIGHT*2).
REQ-007 clk_in  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst_in_n  in  1  asynchronous reset, active-low.
REQ-009 start_in  in  1  single-cycle request to blur one whole image.
REQ-010 level_in  in  2  octave; active width = WIDTH>>level_in, active height = HEIGHT>>level_in; sampled at start.
REQ-011 src_base_in / dst_base_in  in  ADDR_W each  source/destination base addresses; sampled at start.
REQ-012 rd_addr_out  out  ADDR_W  and  rd_en_out  out  1  BRAM read port.
REQ-013 rd_data_in  in  BIT_DEPTH  BRAM read data.
REQ-014 row0_out / row1_out / row2_out  out  3*BIT_DEPTH each  kernel rows to the blur unit.
REQ-015 blur_valid_out  out  1  kernel-valid strobe to the blur unit.
REQ-016 blur_data_in  in  BIT_DEPTH  and  blur_valid_in  in  1  blur unit result.
REQ-017 wr_addr_out  out  ADDR_W, wr_data_out  out  BIT_DEPTH, wr_en_out  out  1  BRAM write port.
REQ-018 busy_out, done_out, error_out  out  1 each  status outputs.

Function
REQ-019 SHALL implement the FSM IDLE -> FETCH -> WAIT_BLUR -> WRITE -> NEXT -> (FETCH | DONE) -> IDLE.
REQ-020 IDLE: start_in=1 SHALL latch the level and both bases, set (x,y)=(0,0), clear error_out, and enter FETCH; start_in outside IDLE SHALL be ignored.
REQ-021 FETCH SHALL assert rd_en_out for exactly 9 consecutive cycles, in order ky=0..2 outer, kx=0..2 inner.
REQ-022 Read address SHALL be src_base + cy*w + cx, where cx = clamp(x+kx-1, 0, w-1) and cy = clamp(y+ky-1, 0, h-1) (edge saturation).
REQ-023 Each read's data SHALL be captured RD_LATENCY cycles after its issue into kernel slot (ky,kx).
REQ-024 Packing: row<ky>_out[BIT_DEPTH*(kx+1)-1 : BIT_DEPTH*kx] = slot (ky,kx).
REQ-025 The cycle after the 9th capture, blur_valid_out SHALL be 1 for one cycle with rows stable, then enter WAIT_BLUR; rows SHALL hold until the next FETCH.
REQ-026 WAIT_BLUR: blur_valid_in=1 SHALL register blur_data_in and enter WRITE.
REQ-027 WAIT_BLUR: after TIMEOUT cycles with no blur_valid_in, error_out SHALL set (sticky until the next accepted start) and the FSM SHALL return to IDLE with no write.
REQ-028 WRITE: wr_en_out SHALL be 1 for one cycle, with wr_addr_out = dst_base + y*w + x and wr_data_out = the registered result.
REQ-029 NEXT: if x<w-1 then x++; else x=0 and y++; after (w-1,h-1) enter DONE, otherwise FETCH.
REQ-030 DONE: done_out SHALL be 1 for exactly one cycle, then return to IDLE.
REQ-031 busy_out SHALL be 1 in every state except IDLE.
REQ-032 Address arithmetic SHALL be ADDR_W wide, modulo 2^ADDR_W; y*w SHALL be computed as a shift by log2(w).
REQ-033 Per-pixel period SHALL be 9 + RD_LATENCY + 1 + (blur wait) + 2 cycles.

Reset
REQ-034 rst_in_n=0 SHALL immediately force the FSM to IDLE, x=y=0, kernel slots=0, all outputs=0, and discard any in-flight read data.
REQ-035 After reset release, the first accepted start SHALL begin at pixel (0,0).

Verification (WIDTH=HEIGHT=4, RD_LATENCY=2, memory mem[a]=a, src_base=0, dst_base=16, blur model returns the centre pixel 3 cycles after strobe)
REQ-036 Corner: first kernel of level 0 -> row0=[0,0,1], row1=[0,0,1], row2=[4,4,5] (kx0..2); rd_en_out high for 9 cycles, blur_valid_out 3 cycles after the last read.
REQ-037 Full pass: one start -> 16 blur_valid_out pulses, 16 writes to addresses 16..31 in order with wr_data_out=0..15, exactly one done_out pulse, then busy_out=0.
REQ-038 Level 1 (w=h=2): start -> 4 writes to 16,17,18,19; bottom-right kernel at (1,1) -> every row is [2,3,3] or [2,3,3] clamped, i.e., row0=[0,1,1], row1=[2,3,3], row2=[2,3,3].
REQ-039 Timeout: blur_valid_in held 0 -> error_out=1 after 64 WAIT_BLUR cycles, no wr_en_out, busy_out=0; the next start clears error_out.
REQ-040 Reset mid-FETCH (after 5 reads), then start -> outputs 0 during reset, no stray capture, first kernel again equals the REQ-036 values.
REQ-041 start_in pulsed while busy -> ignored; the pass completes with exactly 16 writes and one done_out.
